// File: rtl/vrased_reset_seq_if.sv
// Bundle between the VRASED monitor bank / core reset and vrased_reset_seq.
// viol_src is a set of level requests from the monitors: there is no valid/ready
// handshake. A request bit is honoured in every cycle it is high, and the
// sequencer never back-pressures it. dbg_state/dbg_cnt expose the sequencer
// FSM state and hold counter for observation only.
interface vrased_reset_seq_if #(
   parameter int CNT_W = 5
);
   logic [5:0]       viol_src;
   logic             cpu_rst;
   logic             busy;
   logic [5:0]       cause;
   logic [7:0]       viol_cnt;
   logic [1:0]       dbg_state;
   logic [CNT_W-1:0] dbg_cnt;

   modport master (
      output viol_src,
      input  cpu_rst, busy, cause, viol_cnt, dbg_state, dbg_cnt
   );

   modport slave (
      input  viol_src,
      output cpu_rst, busy, cause, viol_cnt, dbg_state, dbg_cnt
   );
endinterface

// File: rtl/vrased_reset_seq.sv
// vrased_reset_seq: gathers VRASED monitor reset requests, holds the core in
// reset for at least HOLD_CYCLES, waits for all requests to drop, releases and
// records the violation cause.
// Optional feature: define VRASED_VIOL_LOG_EN to build the saturating 8-bit
// violation-episode counter; otherwise viol_cnt is constant zero.
module vrased_reset_seq #(
   parameter int HOLD_CYCLES = 16,
   parameter int CNT_W       = 5
) (
   input logic                clk,
   input logic                reset,
   vrased_reset_seq_if.slave  rs
);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      HOLD    = 2'b01,
      DRAIN   = 2'b10,
      RELEASE = 2'b11
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [5:0]       viol_q;
   logic             viol_any;
   logic             cpu_rst_q;
   logic             busy_q;
   logic [5:0]       cause_q;

   // Monitor requests are combinational; sample them once before use.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) viol_q <= '0;
      else       viol_q <= rs.viol_src;
   end

   assign viol_any = |viol_q;

   // Sequencer FSM; cpu_rst/busy are registered from the next state so the
   // core reset never glitches.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= HOLD;
         cnt       <= CNT_LOAD;
         cpu_rst_q <= 1'b1;
         busy_q    <= 1'b1;
         cause_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (viol_any) begin
                  state     <= HOLD;
                  cnt       <= CNT_LOAD;
                  cause_q   <= viol_q;
                  cpu_rst_q <= 1'b1;
                  busy_q    <= 1'b1;
               end else begin
                  cpu_rst_q <= 1'b0;
                  busy_q    <= 1'b0;
               end
            end
            HOLD: begin
               cause_q   <= cause_q | viol_q;
               cpu_rst_q <= 1'b1;
               busy_q    <= 1'b1;
               if (viol_any) begin
                  // A fresh request restarts the minimum hold time.
                  cnt <= CNT_LOAD;
               end else if (cnt == '0) begin
                  state <= DRAIN;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end
            DRAIN: begin
               cause_q <= cause_q | viol_q;
               busy_q  <= 1'b1;
               if (!viol_any) begin
                  state     <= RELEASE;
                  cpu_rst_q <= 1'b0;
               end else begin
                  cpu_rst_q <= 1'b1;
               end
            end
            RELEASE: begin
               if (viol_any) begin
                  state     <= HOLD;
                  cnt       <= CNT_LOAD;
                  cause_q   <= cause_q | viol_q;
                  cpu_rst_q <= 1'b1;
                  busy_q    <= 1'b1;
               end else begin
                  state     <= IDLE;
                  cpu_rst_q <= 1'b0;
                  busy_q    <= 1'b0;
               end
            end
            default: begin
               state     <= HOLD;
               cnt       <= CNT_LOAD;
               cpu_rst_q <= 1'b1;
               busy_q    <= 1'b1;
            end
         endcase
      end
   end

`ifdef VRASED_VIOL_LOG_EN
   logic [7:0] viol_cnt_q;
   logic       episode_start;

   // A new episode starts whenever a request pulls the core back into HOLD
   // from a released state.
   assign episode_start = viol_any && ((state == IDLE) || (state == RELEASE));

   // Saturating episode counter, cleared only by power-on reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                   viol_cnt_q <= '0;
      else if (episode_start && viol_cnt_q != 8'hFF) viol_cnt_q <= viol_cnt_q + 8'd1;
   end

   assign rs.viol_cnt = viol_cnt_q;
`else
   assign rs.viol_cnt = 8'h00;
`endif

   assign rs.cpu_rst   = cpu_rst_q;
   assign rs.busy      = busy_q;
   assign rs.cause     = cause_q;
   assign rs.dbg_state = state;
   assign rs.dbg_cnt   = cnt;

endmodule

// File: tb/tb_vrased_reset_seq.sv
// Bench for vrased_reset_seq: per-cycle scoreboard against a reference model of
// the sequencer, a table of isolated violation episodes, and hand-written
// sequences for hold extension, re-entry from RELEASE, counter saturation and
// asynchronous reset.
module tb_vrased_reset_seq;

   localparam int H     = 16;
   localparam int CNT_W = 5;
   localparam int W     = 1 + 1 + 6 + 8 + 2 + CNT_W;
`ifdef VRASED_VIOL_LOG_EN
   localparam int LOG = 1;
`else
   localparam int LOG = 0;
`endif

   logic clk;
   logic reset;

   vrased_reset_seq_if #(.CNT_W(CNT_W)) ifc ();

   vrased_reset_seq #(.HOLD_CYCLES(H), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .rs    (ifc.slave)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // reference model
   logic [1:0]       m_state;
   logic [CNT_W-1:0] m_cnt;
   logic             m_rst;
   logic             m_busy;
   logic [5:0]       m_cause;
   logic [7:0]       m_vcnt;
   logic [5:0]       m_q;

   logic [W-1:0] exp_q[$];
   int checks   = 0;
   int failures = 0;
   int hi_cnt   = 0;

   task automatic model_reset();
      m_state = 2'b01; m_cnt = CNT_W'(H - 1); m_rst = 1'b1; m_busy = 1'b1;
      m_cause = '0; m_vcnt = '0; m_q = '0;
   endtask

   task automatic model_bump();
      if (LOG == 1 && m_vcnt != 8'hFF) m_vcnt = m_vcnt + 8'd1;
   endtask

   task automatic model_edge(input logic [5:0] src);
      logic any;
      any = |m_q;
      case (m_state)
         2'b00: if (any) begin
            m_state = 2'b01; m_cnt = CNT_W'(H - 1); m_cause = m_q; model_bump();
         end
         2'b01: begin
            m_cause = m_cause | m_q;
            if (any)              m_cnt = CNT_W'(H - 1);
            else if (m_cnt == 0)  m_state = 2'b10;
            else                  m_cnt = m_cnt - 1'b1;
         end
         2'b10: begin
            m_cause = m_cause | m_q;
            if (!any) m_state = 2'b11;
         end
         default: if (any) begin
            m_state = 2'b01; m_cnt = CNT_W'(H - 1); m_cause = m_cause | m_q; model_bump();
         end else begin
            m_state = 2'b00;
         end
      endcase
      m_rst  = (m_state == 2'b01) || (m_state == 2'b10);
      m_busy = (m_state != 2'b00);
      m_q    = src;
   endtask

   // scoreboard
   task automatic push_expected();
      exp_q.push_back({m_rst, m_busy, m_cause, m_vcnt, m_state, m_cnt});
   endtask

   task automatic compare_outputs(input string name);
      logic [W-1:0] act;
      logic [W-1:0] exp;
      act = {ifc.cpu_rst, ifc.busy, ifc.cause, ifc.viol_cnt, ifc.dbg_state, ifc.dbg_cnt};
      exp = exp_q.pop_front();
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t act={rst,busy,cause,vcnt,st,cnt}=%h exp=%h", name, $time, act, exp);
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   // driver: one clock cycle with the given request pattern
   task automatic tick(input logic [5:0] src);
      ifc.viol_src = src;
      @(posedge clk);
      #1;
      if (reset) model_reset();
      else       model_edge(src);
      push_expected();
      compare_outputs("cycle");
      if (ifc.cpu_rst) hi_cnt++;
   endtask

   task automatic wait_idle(input string name);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 400 && !done; i++) begin
         tick(6'b0);
         if (!ifc.busy) done = 1'b1;
      end
      check({name, "_idle_timeout"}, {31'b0, done}, 32'd1);
   endtask

   task automatic wait_hold_cnt(input string name, input int value);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         tick(6'b0);
         if (ifc.dbg_state == 2'b01 && ifc.dbg_cnt == CNT_W'(value)) done = 1'b1;
      end
      check({name, "_hold_timeout"}, {31'b0, done}, 32'd1);
   endtask

   typedef struct {
      logic [5:0] src;
      int         len;
      int         exp_hi;
      logic [5:0] exp_cause;
   } vec_t;

   vec_t vecs[5];

   initial begin
      logic [7:0] base;

      vecs[0] = '{src: 6'b000100, len: 1,  exp_hi: 17, exp_cause: 6'b000100};
      vecs[1] = '{src: 6'b000010, len: 40, exp_hi: 56, exp_cause: 6'b000010};
      vecs[2] = '{src: 6'b100001, len: 3,  exp_hi: 19, exp_cause: 6'b100001};
      vecs[3] = '{src: 6'b011000, len: 2,  exp_hi: 18, exp_cause: 6'b011000};
      vecs[4] = '{src: 6'b111111, len: 1,  exp_hi: 17, exp_cause: 6'b111111};

      // power-on reset
      reset = 1'b1;
      ifc.viol_src = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      push_expected();
      compare_outputs("reset_state");
      check("reset_cpu_rst", {31'b0, ifc.cpu_rst}, 32'd1);

      // release: 16 HOLD + 1 DRAIN cycles with cpu_rst high, then RELEASE, IDLE
      reset  = 1'b0;
      hi_cnt = 1;
      wait_idle("por");
      check("por_hi_cycles", hi_cnt, 32'd17);
      check("por_cause", {26'b0, ifc.cause}, 32'd0);

      // table of isolated episodes from IDLE
      for (int v = 0; v < 5; v++) begin
         base   = m_vcnt;
         hi_cnt = 0;
         for (int j = 0; j < vecs[v].len; j++) tick(vecs[v].src);
         wait_idle("vec");
         check($sformatf("vec%0d_hi_cycles", v), hi_cnt, vecs[v].exp_hi);
         check($sformatf("vec%0d_cause", v), {26'b0, ifc.cause}, {26'b0, vecs[v].exp_cause});
         check($sformatf("vec%0d_viol_cnt", v), {24'b0, ifc.viol_cnt}, 32'(base) + LOG);
         // cause is held in IDLE
         tick(6'b0);
         tick(6'b0);
         check($sformatf("vec%0d_cause_hold", v), {26'b0, ifc.cause}, {26'b0, vecs[v].exp_cause});
      end

      // hold extension: request at cnt==3 reloads the counter
      base = m_vcnt;
      tick(6'b000100);
      wait_hold_cnt("ext", 3);
      tick(6'b000001);
      tick(6'b0);
      check("ext_cnt_reload", {27'b0, ifc.dbg_cnt}, 32'd15);
      wait_idle("ext");
      check("ext_cause", {26'b0, ifc.cause}, 32'b000101);
      check("ext_viol_cnt", {24'b0, ifc.viol_cnt}, 32'(base) + LOG);

      // request in the RELEASE cycle re-enters HOLD
      base = m_vcnt;
      tick(6'b000100);
      for (int i = 0; i < 40 && ifc.dbg_state != 2'b10; i++) tick(6'b0);
      check("rel_reached_drain", {30'b0, ifc.dbg_state}, 32'd2);
      tick(6'b000010);
      check("rel_cpu_rst_low", {31'b0, ifc.cpu_rst}, 32'd0);
      check("rel_busy", {31'b0, ifc.busy}, 32'd1);
      tick(6'b0);
      check("rel_rehold_cpu_rst", {31'b0, ifc.cpu_rst}, 32'd1);
      check("rel_viol_cnt", {24'b0, ifc.viol_cnt}, 32'(base) + 2 * LOG);
      wait_idle("rel");
      check("rel_cause", {26'b0, ifc.cause}, 32'b000110);

      // many isolated episodes: counter saturates
      for (int e = 0; e < 300; e++) begin
         tick(6'(1 << (e % 6)));
         wait_idle("sat");
      end
      check("sat_viol_cnt", {24'b0, ifc.viol_cnt}, (LOG == 1) ? 32'hFF : 32'h0);

      // asynchronous reset in the middle of HOLD
      tick(6'b001000);
      wait_hold_cnt("arst", 8);
      reset = 1'b1;
      #1;
      check("arst_cpu_rst", {31'b0, ifc.cpu_rst}, 32'd1);
      check("arst_state", {30'b0, ifc.dbg_state}, 32'd1);
      check("arst_cnt", {27'b0, ifc.dbg_cnt}, 32'd15);
      check("arst_viol_cnt", {24'b0, ifc.viol_cnt}, 32'd0);
      check("arst_cause", {26'b0, ifc.cause}, 32'd0);
      model_reset();
      tick(6'b0);
      tick(6'b0);
      reset = 1'b0;
      hi_cnt = 1;
      wait_idle("arst");
      check("arst_hi_cycles", hi_cnt, 32'd17);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
